// File: rtl/seven_segment_mux.sv
// seven_segment_mux
//   Parametrised multiplexed seven-segment driver. A WIDTH-bit unsigned value
//   is captured through a load handshake and converted to BCD with a
//   sequential double-dabble (one bit per clock). DIGITS common-anode digits
//   are scanned, each enabled for REFRESH_DIV clocks, with optional
//   leading-zero blanking and an all-dash overflow indication.
//
// Parameters:
//   DIGITS      number of digits driven (1..8)
//   WIDTH       bit width of the input value (1..27)
//   REFRESH_DIV clk cycles each digit stays enabled (>=2)
//   BLANK_LZ    1 = blank leading zero digits, 0 = show all digits
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   value     unsigned binary value to display
//   load      capture request, honoured only while busy=0
//   blink     per-digit blink enables (only with SEG_BLINK_EN defined)
//   busy      conversion in progress, load ignored while high
//   overflow  displayed value exceeded 10^DIGITS-1
//   seg       segments {g,f,e,d,c,b,a}, active-low
//   an        digit enables, one-hot active-low, bit 0 = least significant
//
// Optional feature macro: SEG_BLINK_EN
//   Adds the blink port and a frame counter; bit 5 of the frame counter is
//   the blink phase, during which digits with their blink bit set are blank.

module seven_segment_mux #(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 131072,
    parameter int BLANK_LZ    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
`ifdef SEG_BLINK_EN
    input  logic [DIGITS-1:0] blink,
`endif
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic longint unsigned max_display(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam longint unsigned MAX_VAL = max_display(DIGITS);

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Converter FSM: IDLE -> SHIFT (WIDTH cycles) -> COMMIT -> IDLE
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] shift_reg;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] bit_cnt;
    logic             ovf_pending;
    logic [BCD_W-1:0] disp_digits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (load) state_next = S_SHIFT;
            S_SHIFT:  if (bit_cnt == CNT_W'(WIDTH - 1)) state_next = S_COMMIT;
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Add-3 correction applied to every BCD digit before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5) begin
                bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            bcd         <= '0;
            bit_cnt     <= '0;
            ovf_pending <= 1'b0;
            disp_digits <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        shift_reg   <= value;
                        bcd         <= '0;
                        bit_cnt     <= '0;
                        ovf_pending <= (64'(value) > MAX_VAL);
                    end
                end
                S_SHIFT: begin
                    // Carries out of the top digit are dropped; ovf_pending
                    // already flags any value that does not fit.
                    bcd       <= {bcd_adj[BCD_W-2:0], shift_reg[WIDTH-1]};
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                end
                S_COMMIT: begin
                    disp_digits <= bcd;
                    overflow    <= ovf_pending;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Refresh counter and scan index
    // ------------------------------------------------------------------
    logic [REF_W-1:0] refresh_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic             refresh_wrap;
    logic             scan_last;

    assign refresh_wrap = (refresh_cnt == REF_W'(REFRESH_DIV - 1));
    assign scan_last    = (scan_idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_wrap) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_last ? '0 : scan_idx + IDX_W'(1);
        end else begin
            refresh_cnt <= refresh_cnt + REF_W'(1);
        end
    end

`ifdef SEG_BLINK_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (refresh_wrap && scan_last) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Segment / anode selection (registered outputs)
    // ------------------------------------------------------------------
    logic [3:0]        cur_digit;
    logic              upper_zero;
    logic              lz_blank;
    logic [6:0]        seg_next;
    logic [DIGITS-1:0] an_next;

    always_comb begin
        cur_digit = disp_digits[scan_idx*4 +: 4];

        // Digit i is a leading zero when digits i..DIGITS-1 are all zero.
        upper_zero = 1'b1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if ((d >= 32'(scan_idx)) && (disp_digits[d*4 +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        lz_blank = (BLANK_LZ != 0) && (scan_idx != '0) && upper_zero;

        if (overflow) begin
            seg_next = SEG_DASH;
        end else if (lz_blank) begin
            seg_next = SEG_BLANK;
        end else begin
            seg_next = digit_pattern(cur_digit);
        end

`ifdef SEG_BLINK_EN
        if (frame_cnt[5] && blink[scan_idx]) begin
            seg_next = SEG_BLANK;
        end
`endif

        an_next = ~(DIGITS'(1) << scan_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seven_segment_mux.sv
module tb_seven_segment_mux;

    localparam int W   = 14;
    localparam int DG  = 4;
    localparam int REF = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  value;
    logic          load;
    logic          busy0, busy1;
    logic          ovf0, ovf1;
    logic [6:0]    seg0, seg1;
    logic [DG-1:0] an0, an1;

    int checks = 0;
    int errors = 0;
    bit exp_ovf = 1'b0;

    always #5 clk = ~clk;

    seven_segment_mux #(.DIGITS(DG), .WIDTH(W), .REFRESH_DIV(REF), .BLANK_LZ(1)) dut0 (
        .clk(clk), .rst(rst), .value(value), .load(load),
`ifdef SEG_BLINK_EN
        .blink('0),
`endif
        .busy(busy0), .overflow(ovf0), .seg(seg0), .an(an0)
    );

    seven_segment_mux #(.DIGITS(DG), .WIDTH(W), .REFRESH_DIV(REF), .BLANK_LZ(0)) dut1 (
        .clk(clk), .rst(rst), .value(value), .load(load),
`ifdef SEG_BLINK_EN
        .blink('0),
`endif
        .busy(busy1), .overflow(ovf1), .seg(seg1), .an(an1)
    );

    function automatic logic [6:0] pattern(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference: what digit i shows for displayed value v.
    function automatic logic [6:0] exp_seg(input int v, input int i, input bit blz);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (v > 9999) return 7'b0111111;
        if (blz && (i > 0) && (v < p)) return 7'b1111111;
        return pattern((v / p) % 10);
    endfunction

    // Scan both DUTs for 24 cycles and compare each digit's last seen pattern.
    task automatic check_display(input string tag, input int v);
        logic [6:0] got0 [DG];
        logic [6:0] got1 [DG];
        bit         seen0 [DG];
        bit         seen1 [DG];
        logic [DG-1:0] oh;
        for (int i = 0; i < DG; i++) begin
            seen0[i] = 1'b0;
            seen1[i] = 1'b0;
            got0[i]  = 'x;
            got1[i]  = 'x;
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            for (int i = 0; i < DG; i++) begin
                oh = DG'(1) << i;
                if (an0 == ~oh) begin got0[i] = seg0; seen0[i] = 1'b1; end
                if (an1 == ~oh) begin got1[i] = seg1; seen1[i] = 1'b1; end
            end
        end
        for (int i = 0; i < DG; i++) begin
            checks++;
            if (!seen0[i] || got0[i] !== exp_seg(v, i, 1'b1)) begin
                errors++;
                $display("FAIL %s_lz_digit%0d: seen=%0d got=%b expected=%b", tag, i, seen0[i], got0[i], exp_seg(v, i, 1'b1));
            end
            checks++;
            if (!seen1[i] || got1[i] !== exp_seg(v, i, 1'b0)) begin
                errors++;
                $display("FAIL %s_nolz_digit%0d: seen=%0d got=%b expected=%b", tag, i, seen1[i], got1[i], exp_seg(v, i, 1'b0));
            end
        end
    endtask

    task automatic do_convert(input string tag, input int v);
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_before: busy got=%b expected=0", tag, busy0);
        end
        value = W'(v);
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        // Samples after edges T .. T+W: busy high, overflow still old.
        for (int j = 0; j <= W; j++) begin
            checks++;
            if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy_T+%0d: got=%b/%b expected=1", tag, j, busy0, busy1);
            end
            checks++;
            if (ovf0 !== exp_ovf) begin
                errors++;
                $display("FAIL %s_ovf_hold_T+%0d: got=%b expected=%b", tag, j, ovf0, exp_ovf);
            end
            @(negedge clk);
        end
        exp_ovf = (v > 9999);
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_done: got=%b/%b expected=0", tag, busy0, busy1);
        end
        checks++;
        if (ovf0 !== exp_ovf || ovf1 !== exp_ovf) begin
            errors++;
            $display("FAIL %s_ovf_commit: got=%b/%b expected=%b", tag, ovf0, ovf1, exp_ovf);
        end
        @(negedge clk);
        check_display(tag, v);
    endtask

    task automatic test_reset;
        logic [DG-1:0] oh;
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (an0 !== 4'hF || seg0 !== 7'h7F || busy0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an=%b seg=%b busy=%b ovf=%b expected an=1111 seg=1111111 busy=0 ovf=0", an0, seg0, busy0, ovf0);
        end
        rst = 1'b0;
        // After release edge k, the anode reflects index floor((k-1)/REF) mod DG.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            oh = DG'(1) << (((k - 1) / REF) % DG);
            checks++;
            if (an0 !== ~oh || an1 !== ~oh) begin
                errors++;
                $display("FAIL scan_an_edge%0d: got=%b/%b expected=%b", k, an0, an1, ~oh);
            end
            checks++;
            if (seg0 !== exp_seg(0, ((k - 1) / REF) % DG, 1'b1) || seg1 !== exp_seg(0, 0, 1'b0)) begin
                errors++;
                $display("FAIL scan_seg_edge%0d: got=%b/%b expected=%b/%b", k, seg0, seg1,
                         exp_seg(0, ((k - 1) / REF) % DG, 1'b1), exp_seg(0, 0, 1'b0));
            end
        end
    endtask

    task automatic test_directed;
        do_convert("v1234", 1234);
        do_convert("v7", 7);
        do_convert("v12000", 12000);
        do_convert("v0", 0);
        do_convert("v9999", 9999);
        do_convert("v10000", 10000);
        do_convert("v16383", 16383);
        do_convert("v1000", 1000);
    endtask

    task automatic test_random;
        for (int n = 0; n < 12; n++) begin
            do_convert($sformatf("rand%0d", n), int'($urandom_range(16383, 0)));
        end
    endtask

    task automatic test_load_held;
        int rises;
        bit prev;
        rises = 0;
        prev  = 1'b0;
        @(negedge clk);
        value = W'(1234);
        load  = 1'b1;
        // Sample c is taken after edge T+c (T = first capture).
        for (int c = 0; c <= 2 * W + 3; c++) begin
            @(negedge clk);
            if (c == 3) value = W'(15000);
            if (busy0 && !prev) rises++;
            prev = busy0;
            if (c == W + 1) begin
                checks++;
                if (busy0 !== 1'b0 || ovf0 !== 1'b0) begin
                    errors++;
                    $display("FAIL held_first_commit: busy=%b ovf=%b expected busy=0 ovf=0", busy0, ovf0);
                end
            end
            if (c == W + 2) begin
                checks++;
                if (busy0 !== 1'b1) begin
                    errors++;
                    $display("FAIL held_recapture: busy got=%b expected=1", busy0);
                end
            end
        end
        load = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL held_second_commit: busy=%b ovf=%b expected busy=0 ovf=1", busy0, ovf0);
        end
        checks++;
        if (rises !== 2) begin
            errors++;
            $display("FAIL held_capture_count: got=%0d expected=2", rises);
        end
        exp_ovf = 1'b1;
        check_display("held", 15000);
    endtask

    task automatic test_load_ignored;
        do_convert("pre_ign", 56);
        @(negedge clk);
        value = W'(321);
        load  = 1'b1;
        @(negedge clk);
        // Pulse new loads with a different value while busy.
        for (int c = 0; c < W + 3; c++) begin
            value = W'(9000 + c);
            load  = (c % 2 == 0) && (c < W - 1);
            @(negedge clk);
        end
        load = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL ignored_no_queue: busy got=%b expected=0", busy0);
        end
        exp_ovf = 1'b0;
        check_display("ignored", 321);
    endtask

    task automatic test_reset_mid;
        do_convert("pre_rst", 12000);
        @(negedge clk);
        value = W'(4321);
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || ovf0 !== 1'b0 || an0 !== 4'hF || seg0 !== 7'h7F) begin
            errors++;
            $display("FAIL midrst_state: busy=%b ovf=%b an=%b seg=%b expected 0 0 1111 1111111", busy0, ovf0, an0, seg0);
        end
        rst = 1'b0;
        exp_ovf = 1'b0;
        repeat (W + 4) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: busy=%b ovf=%b expected 0 0", busy0, ovf0);
        end
        check_display("midrst", 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_load_held();
        test_load_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
